// File: rtl/sample_dac_tx.sv
// Sample FIFO feeding an MSB-first serializer for a 3-wire SPI-style DAC (sclk, sdata, cs_n).
// Define SAMPLE_DAC_OFFSET_BINARY_EN to invert each sample's MSB at load (offset-binary output).
module sample_dac_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          dac_sclk,
    output logic                          dac_sdata,
    output logic                          dac_cs_n,
    output logic                          busy,
    output logic                          underrun
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;
    logic                push_c, load_c;
    logic                div_mid_c, div_last_c, bit_last_c, gap_last_c, fifo_empty_c;
    logic [DATA_W-1:0]   head_c;

    // in_ready comes from registered occupancy only, so a full FIFO refuses even on a pop cycle
    assign push_c       = in_valid && in_ready_q;
    assign fifo_empty_c = (level_q == '0);
    assign div_mid_c    = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_last_c   = (div_q == DIV_W'(2 * CLK_DIV - 1));
    assign bit_last_c   = (bit_q == BIT_W'(DATA_W - 1));
    assign gap_last_c   = (gap_q == GAP_W'(GAP_CYC - 1));

`ifdef SAMPLE_DAC_OFFSET_BINARY_EN
    assign head_c = mem_q[rd_ptr_q] ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    assign head_c = mem_q[rd_ptr_q];
`endif

    assign level_d    = level_q + LVL_W'(push_c) - LVL_W'(load_c);
    assign in_ready_d = (level_d != LVL_W'(FIFO_DEPTH));
    assign busy_d     = (state_d != ST_IDLE);
    // Registered so it is high during the final GAP cycle exactly when that cycle sees an empty FIFO
    assign underrun_d = (state_d == ST_GAP) && (gap_d == GAP_W'(GAP_CYC - 1)) && (level_d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
            shift_q    <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            gap_q      <= '0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + PTR_W'(push_c);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(load_c);
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Next state; load_c pops the FIFO head into the shifter
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    load_c  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_last_c && bit_last_c) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last_c) begin
                    if (!fifo_empty_c) begin
                        load_c  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer datapath: sclk low then high per bit, data advances as sclk falls
    always_comb begin
        shift_d = shift_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        cs_n_d  = cs_n_q;
        if (load_c) begin
            shift_d = head_c;
            sdata_d = head_c[DATA_W-1];
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    div_d = div_q + DIV_W'(1);
                    if (div_mid_c) begin
                        sclk_d = 1'b1;
                    end
                    if (div_last_c) begin
                        div_d  = '0;
                        sclk_d = 1'b0;
                        if (bit_last_c) begin
                            cs_n_d  = 1'b1;
                            sdata_d = 1'b0;
                            gap_d   = '0;
                        end else begin
                            bit_d   = bit_q + BIT_W'(1);
                            shift_d = {shift_q[DATA_W-2:0], 1'b0};
                            sdata_d = shift_q[DATA_W-2];
                        end
                    end
                end
                ST_GAP: begin
                    gap_d = gap_last_c ? '0 : gap_q + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign fifo_level = level_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdata  = sdata_q;
    assign dac_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_sample_dac_tx.sv
// Directed bench for sample_dac_tx: a default-parameter instance and a CLK_DIV=1/GAP_CYC=1 instance,
// each watched by a DAC-side capture monitor.
module tb_sample_dac_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid0 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        in_ready0, in_ready1;
    logic [2:0]  lvl0, lvl1;
    logic        sclk0, sclk1, sdata0, sdata1, cs0, cs1, busy0, busy1, ur0, ur1;
    logic [1:0]  sclk_w, sdata_w, cs_w, ur_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sample_dac_tx u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid0),
        .in_ready(in_ready0), .fifo_level(lvl0), .dac_sclk(sclk0), .dac_sdata(sdata0),
        .dac_cs_n(cs0), .busy(busy0), .underrun(ur0)
    );

    sample_dac_tx #(.CLK_DIV(1), .GAP_CYC(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
        .in_ready(in_ready1), .fifo_level(lvl1), .dac_sclk(sclk1), .dac_sdata(sdata1),
        .dac_cs_n(cs1), .busy(busy1), .underrun(ur1)
    );

    assign sclk_w  = {sclk1, sclk0};
    assign sdata_w = {sdata1, sdata0};
    assign cs_w    = {cs1, cs0};
    assign ur_w    = {ur1, ur0};

    // DAC-side capture state, per instance
    logic        mon_clr = 1'b0;
    logic        prev_sclk [2];
    logic [15:0] shreg [2];
    logic [15:0] cap_word [2][8];
    int          cap_len [2][8];
    int          cap_gap [2][8];
    int          cap_rise [2][8];
    int          n_cap [2];
    int          low_cnt [2];
    int          high_cnt [2];
    int          last_gap [2];
    int          nrise [2];
    int          stray [2];
    int          n_ur [2];
    int          ur_pos [2];

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (mon_clr) begin
                n_cap[c] = 0; low_cnt[c] = 0; high_cnt[c] = 0; last_gap[c] = 0;
                nrise[c] = 0; stray[c] = 0; n_ur[c] = 0; ur_pos[c] = 0; shreg[c] = '0;
            end else if (!cs_w[c]) begin
                if (low_cnt[c] == 0) begin
                    last_gap[c] = high_cnt[c];
                    nrise[c] = 0;
                end
                low_cnt[c]++;
                if (sclk_w[c] && !prev_sclk[c]) begin
                    shreg[c] = {shreg[c][14:0], sdata_w[c]};
                    nrise[c]++;
                end
                if (ur_w[c]) begin
                    n_ur[c]++;
                    ur_pos[c] = -1;
                end
            end else begin
                if (low_cnt[c] != 0) begin
                    if (n_cap[c] < 8) begin
                        cap_word[c][n_cap[c]] = shreg[c];
                        cap_len[c][n_cap[c]]  = low_cnt[c];
                        cap_gap[c][n_cap[c]]  = last_gap[c];
                        cap_rise[c][n_cap[c]] = nrise[c];
                    end
                    n_cap[c]++;
                    low_cnt[c] = 0;
                    high_cnt[c] = 0;
                end
                high_cnt[c]++;
                if (sclk_w[c] || sdata_w[c]) stray[c]++;
                if (ur_w[c]) begin
                    n_ur[c]++;
                    ur_pos[c] = high_cnt[c];
                end
            end
            prev_sclk[c] = sclk_w[c];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] xb(input logic [15:0] d);
`ifdef SAMPLE_DAC_OFFSET_BINARY_EN
        return d ^ 16'h8000;
`else
        return d;
`endif
    endfunction

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(negedge clk);
    endtask

    // Present one sample for one edge; call at a negedge, returns at the next negedge
    task automatic send(input int ch, input logic [15:0] d);
        in_data   = d;
        in_valid0 = (ch == 0);
        in_valid1 = (ch == 1);
        @(negedge clk);
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int ch, input int budget, input string tag);
        int n = 0;
        while (((ch == 0) ? (busy0 || lvl0 != 0) : (busy1 || lvl1 != 0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'((ch == 0) ? busy0 : busy1), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    logic [15:0] tv [6];
    logic        acc [6];
    int          n_acc;
    logic [15:0] w;

    initial begin
        #200000;
        $display("FAIL global_timeout: got=stuck exp=done");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", 32'(cs0), 32'd1);
        check_eq("rst_sclk", 32'(sclk0), 32'd0);
        check_eq("rst_sdata", 32'(sdata0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_underrun", 32'(ur0), 32'd0);
        check_eq("rst_level", 32'(lvl0), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready0), 32'd1);
        reset = 1'b1;
        clr_mon();

        // Single frame 0x7FFF, latency and timing
        send(0, 16'h7FFF);
        check_eq("lat_level", 32'(lvl0), 32'd1);
        check_eq("lat_cs_before", 32'(cs0), 32'd1);
        @(negedge clk);
        w = xb(16'h7FFF);
        check_eq("lat_cs_low", 32'(cs0), 32'd0);
        check_eq("lat_msb", 32'(sdata0), 32'(w[15]));
        check_eq("lat_busy", 32'(busy0), 32'd1);
        check_eq("lat_level_pop", 32'(lvl0), 32'd0);
        wait_idle(0, 200, "t2_idle");
        check_eq("t2_nframes", 32'(n_cap[0]), 32'd1);
        check_eq("t2_word", 32'(cap_word[0][0]), 32'(xb(16'h7FFF)));
        check_eq("t2_cs_len", 32'(cap_len[0][0]), 32'd64);
        check_eq("t2_rises", 32'(cap_rise[0][0]), 32'd16);
        check_eq("t2_n_ur", 32'(n_ur[0]), 32'd1);
        check_eq("t2_ur_pos", 32'(ur_pos[0]), 32'd2);
        check_eq("t2_stray", 32'(stray[0]), 32'd0);

        // Back-to-back frames
        clr_mon();
        tv[0] = 16'hA5A5; tv[1] = 16'h0001; tv[2] = 16'h8000;
        for (int i = 0; i < 3; i++) send(0, tv[i]);
        wait_idle(0, 400, "t3_idle");
        check_eq("t3_nframes", 32'(n_cap[0]), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t3_word%0d", i), 32'(cap_word[0][i]), 32'(xb(tv[i])));
            check_eq($sformatf("t3_len%0d", i), 32'(cap_len[0][i]), 32'd64);
        end
        check_eq("t3_gap1", 32'(cap_gap[0][1]), 32'd2);
        check_eq("t3_gap2", 32'(cap_gap[0][2]), 32'd2);
        check_eq("t3_n_ur", 32'(n_ur[0]), 32'd1);
        check_eq("t3_stray", 32'(stray[0]), 32'd0);

        // Flood: six samples offered on consecutive edges, FIFO fills to 4
        clr_mon();
        tv[0] = 16'h1111; tv[1] = 16'h2222; tv[2] = 16'h3333;
        tv[3] = 16'h4444; tv[4] = 16'h5555; tv[5] = 16'h6666;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            acc[k] = in_ready0;
            if (in_ready0) n_acc++;
            in_data = tv[k];
            in_valid0 = 1'b1;
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        check_eq("t4_level_full", 32'(lvl0), 32'd4);
        check_eq("t4_ready_low", 32'(in_ready0), 32'd0);
        check_eq("t4_n_acc", 32'(n_acc), 32'd5);
        check_eq("t4_last_refused", 32'(acc[5]), 32'd0);
        wait_idle(0, 1000, "t4_idle");
        check_eq("t4_nframes", 32'(n_cap[0]), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq($sformatf("t4_word%0d", i), 32'(cap_word[0][i]), 32'(xb(tv[i])));
        check_eq("t4_n_ur", 32'(n_ur[0]), 32'd1);

        // Offset-binary corner values
        clr_mon();
        tv[0] = 16'h7FFF; tv[1] = 16'h8000; tv[2] = 16'h0000;
        for (int i = 0; i < 3; i++) send(0, tv[i]);
        wait_idle(0, 400, "t6_idle");
        check_eq("t6_nframes", 32'(n_cap[0]), 32'd3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t6_word%0d", i), 32'(cap_word[0][i]), 32'(xb(tv[i])));

        // Fast instance: CLK_DIV=1, GAP_CYC=1
        clr_mon();
        send(1, 16'h0F0F);
        wait_idle(1, 200, "t5_idle");
        check_eq("t5_nframes", 32'(n_cap[1]), 32'd1);
        check_eq("t5_word", 32'(cap_word[1][0]), 32'(xb(16'h0F0F)));
        check_eq("t5_cs_len", 32'(cap_len[1][0]), 32'd32);
        check_eq("t5_rises", 32'(cap_rise[1][0]), 32'd16);
        check_eq("t5_ur_pos", 32'(ur_pos[1]), 32'd1);
        check_eq("t5_stray", 32'(stray[1]), 32'd0);

        // Asynchronous reset mid-frame
        send(0, 16'h1234);
        send(0, 16'h5555);
        repeat (20) @(negedge clk);
        check_eq("t1_midframe_cs", 32'(cs0), 32'd0);
        #2 reset = 1'b0;
        #1;
        check_eq("t1_cs_n", 32'(cs0), 32'd1);
        check_eq("t1_sclk", 32'(sclk0), 32'd0);
        check_eq("t1_sdata", 32'(sdata0), 32'd0);
        check_eq("t1_busy", 32'(busy0), 32'd0);
        check_eq("t1_level", 32'(lvl0), 32'd0);
        check_eq("t1_in_ready", 32'(in_ready0), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        clr_mon();
        repeat (100) @(negedge clk);
        check_eq("t1_no_frames", 32'(n_cap[0]), 32'd0);
        check_eq("t1_no_sclk", 32'(stray[0]), 32'd0);
        check_eq("t1_still_idle", 32'(busy0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_dac_tx.md
Name: sample_dac_tx

Overview:
Consumer end of the sample stream produced by the wave-compute core. Accepts 16-bit signed samples over a valid/ready handshake and buffers them in a small FIFO. Serializes each sample MSB-first onto a 3-wire SPI-style DAC link (sclk, sdata, cs_n). Sits between the compute core's result output and the board DAC pins.

Parameters:
DATA_W, 16, sample and frame width in bits
FIFO_DEPTH, 4, sample buffer depth; power of 2, >= 2
CLK_DIV, 2, clk cycles per sclk half-period; >= 1
GAP_CYC, 2, minimum clk cycles cs_n held high between frames; >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  DATA_W  two's-complement sample from compute core
in_valid  in  1  in_data valid this cycle
in_ready  out  1  FIFO can accept a sample; equals !full
fifo_level  out  clog2(FIFO_DEPTH)+1  registered FIFO occupancy, 0..FIFO_DEPTH
dac_sclk  out  1  serial clock to DAC; idles low
dac_sdata  out  1  serial data, MSB first
dac_cs_n  out  1  frame select, active low
busy  out  1  high while in LOAD/SHIFT/GAP
underrun  out  1  one-cycle pulse when a frame ends and the FIFO is empty

Behaviour:
- Reset (reset=0, asynchronous): dac_cs_n=1, dac_sclk=0, dac_sdata=0, busy=0, underrun=0, fifo_level=0, in_ready=1, FSM=IDLE, shift/divider/bit counters=0. Reset mid-frame abandons the frame immediately; no partial resume.
- Push: sample written on a rising edge with in_valid && in_ready. in_ready is derived from registered fifo_level only, so a push while full is refused and has no effect, even if a pop occurs that cycle.
- Pop and push on the same edge (FIFO neither full nor empty): fifo_level unchanged, data order preserved. Pointers wrap modulo FIFO_DEPTH.
- FSM IDLE: if fifo_level != 0, then on the next edge pop the head into the shift register, set dac_cs_n=0, drive dac_sdata=bit DATA_W-1, go to SHIFT.
- FSM SHIFT: each bit lasts 2*CLK_DIV cycles. dac_sclk is low for the first CLK_DIV cycles and high for the next CLK_DIV. dac_sdata is stable for the whole bit, so the DAC samples on the sclk rising edge. Data advances on the edge where sclk returns low. After bit 0, on that same edge, set dac_sclk=0 and dac_cs_n=1, then go to GAP.
- dac_cs_n is low for exactly DATA_W*2*CLK_DIV cycles per frame (64 at defaults).
- FSM GAP: hold dac_cs_n=1 for GAP_CYC cycles. On the final GAP cycle:
  - FIFO non-empty: load the next sample directly (cs_n falls on that edge) and return to SHIFT; back-to-back frame period is DATA_W*2*CLK_DIV+GAP_CYC.
  - FIFO empty: pulse underrun for one cycle and go to IDLE.
- Latency: sample pushed at edge N into an empty FIFO while IDLE gives dac_cs_n low and MSB on dac_sdata after edge N+1.
- dac_sdata returns to 0 when cs_n rises.
- busy=1 in every state except IDLE.

Optional Feature:
Macro: SAMPLE_DAC_OFFSET_BINARY_EN.
- Defined: the MSB of each sample is inverted at load time, so the DAC receives offset binary (0x7FFF->0xFFFF, 0x8000->0x0000, 0x0000->0x8000).
- Undefined: samples are shifted out unmodified as two's complement. No port or timing difference either way.

Test Plan:
1. Hold reset=0 mid-frame after loading 0x1234 -> outputs return to reset values asynchronously, fifo_level=0; after release, no sclk edges until a new push.
2. Defaults; push 0x7FFF once -> cs_n low 64 cycles; 16 sclk rising edges capture 0,1,1,...,1; cs_n high; underrun pulses on the 2nd GAP cycle; busy=0 after.
3. Push 0xA5A5, 0x0001, 0x8000 back-to-back -> three frames, each 64 cycles low, separated by exactly 2 cycles high; captured words equal inputs in order; one underrun after the third.
4. Hold in_valid=1 with 6 distinct samples while IDLE with no pop possible -> first sample popped into frame; in_ready drops when fifo_level=4; exactly 5 samples accepted and transmitted in order; refused samples never appear.
5. CLK_DIV=1, GAP_CYC=1; push 0x0F0F -> sclk toggles every cycle, cs_n low 32 cycles, capture 0x0F0F.
6. With SAMPLE_DAC_OFFSET_BINARY_EN defined; push 0x7FFF, 0x8000, 0x0000 -> captured 0xFFFF, 0x0000, 0x8000.
